// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - condition-code types, constants and NZP helper
package reg_file_pkg;

   typedef logic [2:0] nzp_t;

   localparam nzp_t NZP_N     = 3'b100;
   localparam nzp_t NZP_Z     = 3'b010;
   localparam nzp_t NZP_P     = 3'b001;
   localparam nzp_t NZP_RESET = NZP_Z;

   // Width-independent core: callers reduce their value to sign and zero flags.
   function automatic nzp_t calc_nzp(input logic sign_bit, input logic is_zero);
      nzp_t res;
      if (sign_bit)
         res = NZP_N;
      else if (is_zero)
         res = NZP_Z;
      else
         res = NZP_P;
      return res;
   endfunction

endpackage

// File: rtl/reg_file_cc_register_n.sv
// rtl/reg_file_cc_register_n.sv - load-enabled WIDTH-bit register with sync active-low reset
module register_n #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load)
         data_d = d;
   end

   always_ff @(posedge Clk) begin
      if (!Reset)
         data_q <= '0;
      else
         data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/reg_file_cc.sv
// rtl/reg_file_cc.sv - NUM_REGS x WIDTH register file, 1W/2R, with NZP and BEN state
module reg_file_cc
   import reg_file_pkg::*;
#(
   parameter  int NUM_REGS      = 8,
   parameter  int WIDTH         = 16,
   parameter  int WRITE_THROUGH = 0,
   localparam int AW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LD_REG,
   input  logic [AW-1:0]    DR,
   input  logic [WIDTH-1:0] Data_In,
   input  logic [AW-1:0]    SR1,
   input  logic [AW-1:0]    SR2,
   output logic [WIDTH-1:0] SR1_Out,
   output logic [WIDTH-1:0] SR2_Out,
   input  logic             LD_CC,
   input  logic [WIDTH-1:0] CC_In,
   output logic [2:0]       NZP,
   input  logic             LD_BEN,
   input  logic [2:0]       BR_Cond,
   output logic             BEN
);

   logic [WIDTH-1:0] reg_val [NUM_REGS];

   // Out-of-range DR matches no instance, so such writes fall away naturally.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      register_n #(.WIDTH(WIDTH)) u_reg (
         .Clk   (Clk),
         .Reset (Reset),
         .load  (LD_REG && (DR == AW'(i))),
         .d     (Data_In),
         .q     (reg_val[i])
      );
   end

   // Unmatched (out-of-range) read addresses keep the zero default.
   always_comb begin
      SR1_Out = '0;
      SR2_Out = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (SR1 == AW'(r))
            SR1_Out = ((WRITE_THROUGH != 0) && LD_REG && (DR == AW'(r))) ? Data_In : reg_val[r];
         if (SR2 == AW'(r))
            SR2_Out = ((WRITE_THROUGH != 0) && LD_REG && (DR == AW'(r))) ? Data_In : reg_val[r];
      end
   end

   nzp_t nzp_q;
   nzp_t nzp_d;
   logic ben_q;
   logic ben_d;

   // BEN deliberately samples nzp_q so a simultaneous LD_CC is not seen until next cycle.
   always_comb begin
      nzp_d = nzp_q;
      ben_d = ben_q;
      if (LD_CC)
         nzp_d = calc_nzp(CC_In[WIDTH-1], CC_In == '0);
      if (LD_BEN)
         ben_d = |(BR_Cond & nzp_q);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         nzp_q <= NZP_RESET;
         ben_q <= 1'b0;
      end else begin
         nzp_q <= nzp_d;
         ben_q <= ben_d;
      end
   end

   assign NZP = nzp_q;
   assign BEN = ben_q;

endmodule
